// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM lock sequencer: state encoding, default timing
// and the per-state output decode.
package dcm_ctrl_pkg;

    localparam int RST_CYCLES_DEF    = 8;
    localparam int LOCK_TIMEOUT_DEF  = 500000;
    localparam int SETTLE_CYCLES_DEF = 1024;
    localparam int MAX_RETRIES_DEF   = 4;
    localparam int CNT_W_DEF         = 20;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    typedef struct packed {
        logic dcm_rst;
        logic sys_rst;
        logic ready;
        logic fail;
    } ctrl_out_t;

    // Output levels a state presents once it has been entered; registering this
    // alongside the state keeps ready == ~sys_rst by construction.
    function automatic ctrl_out_t drive_of(state_t s);
        ctrl_out_t o;
        o.dcm_rst = (s == ST_RST_HOLD) || (s == ST_FAIL);
        o.sys_rst = (s != ST_RUN);
        o.ready   = (s == ST_RUN);
        o.fail    = (s == ST_FAIL);
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_lock_sequencer.sv
// Brings a DCM_SP out of reset, qualifies LOCKED and releases the divided-clock
// system reset; retries failed lock attempts and watches for loss of lock.
module dcm_lock_sequencer
    import dcm_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int MAX_RETRIES   = MAX_RETRIES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dcm_locked,
    input  logic       clkin_stopped,
    input  logic       restart,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    logic             lk;
    logic             cs;
    state_t           state;
    ctrl_out_t        outs;
    logic [CNT_W-1:0] timer;
    logic [3:0]       retry_inc;
    logic [7:0]       loss_inc;

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_locked (
        .clk (clk),
        .rst (rst),
        .d   (dcm_locked),
        .q   (lk)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_stopped (
        .clk (clk),
        .rst (rst),
        .d   (clkin_stopped),
        .q   (cs)
    );

    assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
    assign loss_inc  = (loss_cnt == 8'hFF) ? 8'hFF : loss_cnt + 8'd1;

    // restart outranks every state transition; inside WAIT_LOCK a lock seen in
    // the timeout cycle still wins over the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RST_HOLD;
            outs      <= drive_of(ST_RST_HOLD);
            timer     <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else if (restart) begin
            state     <= ST_RST_HOLD;
            outs      <= drive_of(ST_RST_HOLD);
            timer     <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                ST_RST_HOLD: begin
                    if (timer == RST_LAST) begin
                        state <= ST_WAIT_LOCK;
                        outs  <= drive_of(ST_WAIT_LOCK);
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk && !cs) begin
                        state <= ST_SETTLE;
                        outs  <= drive_of(ST_SETTLE);
                        timer <= '0;
                    end else if (timer == LOCK_LAST) begin
                        timer     <= '0;
                        retry_cnt <= retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state <= ST_FAIL;
                            outs  <= drive_of(ST_FAIL);
                        end else begin
                            state <= ST_RST_HOLD;
                            outs  <= drive_of(ST_RST_HOLD);
                        end
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!lk || cs) begin
                        state <= ST_RST_HOLD;
                        outs  <= drive_of(ST_RST_HOLD);
                        timer <= '0;
                    end else if (timer == SETTLE_LAST) begin
                        state     <= ST_RUN;
                        outs      <= drive_of(ST_RUN);
                        timer     <= '0;
                        retry_cnt <= '0;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lk || cs) begin
                        state    <= ST_RST_HOLD;
                        outs     <= drive_of(ST_RST_HOLD);
                        timer    <= '0;
                        loss_cnt <= loss_inc;
                    end
                end
                ST_FAIL: begin
                end
                default: begin
                    state <= ST_RST_HOLD;
                    outs  <= drive_of(ST_RST_HOLD);
                    timer <= '0;
                end
            endcase
        end
    end

    assign dcm_rst   = outs.dcm_rst;
    assign sys_rst   = outs.sys_rst;
    assign ready     = outs.ready;
    assign fail      = outs.fail;
    assign state_dbg = state;

endmodule
